// File: rtl/turingtumble_pkg.sv
// Shared colour constants, checker state encoding and fail-reason codes
// used by the tray checker and other board-level blocks.
package turingtumble_pkg;

  localparam logic BLUE = 1'b0;
  localparam logic RED  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } checker_state_t;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    MISMATCH = 2'd1,
    SHORT    = 2'd2,
    EXTRA    = 2'd3
  } fail_reason_t;

endpackage

// File: rtl/tt_rise_detect.sv
// Rising-edge detector: keeps a one-cycle history of din and flags the
// cycle where din is high after having been sampled low.
module tt_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic din_reg;

  always_ff @(posedge clk) begin
    if (rst) din_reg <= 1'b0;
    else     din_reg <= din;
  end

  assign rise = din & ~din_reg;

endmodule

// File: rtl/tray_checker.sv
// Compares the colours of balls landing in the output tray with a target
// pattern and reports a registered verdict. Optional history output is
// enabled by defining TRAY_CHECKER_HISTORY_EN.
module tray_checker
  import turingtumble_pkg::*;
#(
  parameter int              MAX_BALLS  = 16,
  parameter int              TARGET_LEN = 8,
  parameter logic [MAX_BALLS-1:0] TARGET = 16'h00AA
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         ball_valid,
  input  logic                         ball_color,
  input  logic                         no_balls,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [1:0]                   fail_reason,
  output logic [$clog2(MAX_BALLS)-1:0] mismatch_idx,
  output logic [$clog2(MAX_BALLS):0]   ball_count
`ifdef TRAY_CHECKER_HISTORY_EN
  ,
  output logic [MAX_BALLS-1:0]         history
`endif
);

  localparam int IW = $clog2(MAX_BALLS);
  localparam logic [IW:0]   LAST_IDX = (IW+1)'(TARGET_LEN - 1);
  localparam logic [IW:0]   FULL     = (IW+1)'(MAX_BALLS);
  localparam logic [IW-1:0] LEN_IDX  = IW'(TARGET_LEN);

  checker_state_t state_reg, state_next;
  fail_reason_t   reason_reg, reason_next;
  logic [IW:0]    count_reg, count_next, count_inc;
  logic [IW-1:0]  idx_reg, idx_next;
  logic [MAX_BALLS-1:0] target_bits;
  logic           no_balls_rise;
  logic           ball_ok;

  tt_rise_detect u_no_balls_rise (
    .clk  (clk),
    .rst  (rst),
    .din  (no_balls),
    .rise (no_balls_rise)
  );

  assign target_bits = TARGET;
  // In RUN the count is always below TARGET_LEN, so the low bits index the target.
  assign ball_ok   = (ball_color == target_bits[count_reg[IW-1:0]]);
  assign count_inc = (count_reg == FULL) ? count_reg : count_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      reason_reg <= NONE;
      count_reg  <= '0;
      idx_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      reason_reg <= reason_next;
      count_reg  <= count_next;
      idx_reg    <= idx_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    reason_next = reason_reg;
    count_next  = count_reg;
    idx_next    = idx_reg;
    if (start) begin
      state_next  = RUN;
      reason_next = NONE;
      count_next  = '0;
      idx_next    = '0;
    end else begin
      case (state_reg)
        RUN: begin
          if (ball_valid) begin
            count_next = count_inc;
            if (!ball_ok) begin
              state_next  = FAIL;
              reason_next = MISMATCH;
              idx_next    = count_reg[IW-1:0];
            end else if (count_reg == LAST_IDX) begin
              state_next = PASS;
            end else if (no_balls_rise) begin
              // The ball is counted first, so the first missing slot moves up by one.
              state_next  = FAIL;
              reason_next = SHORT;
              idx_next    = count_inc[IW-1:0];
            end
          end else if (no_balls_rise) begin
            state_next  = FAIL;
            reason_next = SHORT;
            idx_next    = count_reg[IW-1:0];
          end
        end
        PASS: begin
          if (ball_valid) begin
            state_next  = FAIL;
            reason_next = EXTRA;
            idx_next    = LEN_IDX;
            count_next  = count_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy         = (state_reg == RUN);
    done         = (state_reg == PASS) || (state_reg == FAIL);
    pass         = (state_reg == PASS);
    fail_reason  = reason_reg;
    mismatch_idx = idx_reg;
    ball_count   = count_reg;
  end

`ifdef TRAY_CHECKER_HISTORY_EN
  logic [MAX_BALLS-1:0] history_reg;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      history_reg <= '0;
    end else if (state_reg == RUN && ball_valid) begin
      history_reg[count_reg[IW-1:0]] <= ball_color;
    end
  end

  assign history = history_reg;
`endif

endmodule

// File: tb/tb_tray_checker.sv
// Randomised and directed bench for tray_checker with a 4-ball target,
// checked against a queue-based model of the tray rules.
module tb_tray_checker;
  import turingtumble_pkg::*;

  localparam int MAXB = 16;
  localparam int TLEN = 4;
  localparam logic [15:0] TGT = 16'h000A;

  logic clk = 1'b0;
  logic rst = 1'b0, start = 1'b0, ball_valid = 1'b0, ball_color = 1'b0, no_balls = 1'b0;
  logic busy, done, pass;
  logic [1:0] fail_reason;
  logic [3:0] mismatch_idx;
  logic [4:0] ball_count;
`ifdef TRAY_CHECKER_HISTORY_EN
  logic [15:0] history;
`endif

  tray_checker #(.MAX_BALLS(MAXB), .TARGET_LEN(TLEN), .TARGET(TGT)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ball_valid   (ball_valid),
    .ball_color   (ball_color),
    .no_balls     (no_balls),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail_reason  (fail_reason),
    .mismatch_idx (mismatch_idx),
    .ball_count   (ball_count)
`ifdef TRAY_CHECKER_HISTORY_EN
    ,
    .history      (history)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: the run is a list of balls plus three phase flags.
  logic [15:0] tgt_v = TGT;
  bit m_run, m_passed, m_failed, m_prev_nb;
  int m_reason, m_idx;
  int m_balls[$];
  logic [15:0] m_hist;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic void m_fail(input int reason, input int idx);
    m_run = 0; m_passed = 0; m_failed = 1;
    m_reason = reason; m_idx = idx;
  endfunction

  function automatic void model(input bit r, input bit s, input bit v, input bit c, input bit n);
    bit rise;
    int slot;
    if (r) begin
      m_run = 0; m_passed = 0; m_failed = 0; m_reason = 0; m_idx = 0;
      m_balls.delete(); m_hist = '0; m_prev_nb = 0;
      return;
    end
    rise = n && !m_prev_nb;
    m_prev_nb = n;
    if (s) begin
      m_run = 1; m_passed = 0; m_failed = 0; m_reason = 0; m_idx = 0;
      m_balls.delete(); m_hist = '0;
    end else if (m_run) begin
      if (v) begin
        slot = m_balls.size();
        m_balls.push_back(int'(c));
        m_hist[slot] = c;
        if (c != tgt_v[slot])          m_fail(1, slot);
        else if (m_balls.size() == TLEN) begin m_run = 0; m_passed = 1; end
        else if (rise)                 m_fail(2, m_balls.size());
      end else if (rise) begin
        m_fail(2, m_balls.size());
      end
    end else if (m_passed && v) begin
      m_balls.push_back(int'(c));
      m_fail(3, TLEN);
    end
  endfunction

  function automatic int m_count();
    return (m_balls.size() > MAXB) ? MAXB : m_balls.size();
  endfunction

  task automatic step(input bit r, input bit s, input bit v, input bit c, input bit n);
    rst = r; start = s; ball_valid = v; ball_color = c; no_balls = n;
    @(posedge clk);
    model(r, s, v, c, n);
    #1;
    chk("busy", busy, m_run);
    chk("done", done, m_passed || m_failed);
    chk("pass", pass, m_passed);
    chk("fail_reason", fail_reason, m_reason);
    chk("mismatch_idx", mismatch_idx, m_idx);
    chk("ball_count", ball_count, m_count());
`ifdef TRAY_CHECKER_HISTORY_EN
    chk("history", history, m_hist);
`endif
  endtask

  task automatic ball(input bit c);
    step(0, 0, 1, c, no_balls);
    step(0, 0, 0, 0, no_balls);
  endtask

  initial begin
    bit last_v, nb, r, s, v, c;

    // Reset state
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_count", ball_count, 0);
    chk("rst_done", done, 0);
    $display("reset: busy=%0d done=%0d count=%0d", busy, done, ball_count);

    // Matching sequence reaches PASS the cycle after the 4th ball
    step(0, 1, 0, 0, 0);
    ball(0); ball(1); ball(0);
    step(0, 0, 1, 1, 0);
    chk("tp1_pass", pass, 1);
    chk("tp1_count", ball_count, 4);
    chk("tp1_reason", fail_reason, 0);
    $display("pattern 0101: pass=%0d count=%0d", pass, ball_count);
    // One more ball after PASS
    step(0, 0, 0, 0, 0);
    ball(1);
    chk("tp4_reason", fail_reason, 3);
    chk("tp4_idx", mismatch_idx, 4);
    chk("tp4_count", ball_count, 5);
    $display("extra ball: reason=%0d idx=%0d count=%0d", fail_reason, mismatch_idx, ball_count);

    // Colour mismatch on second ball; later balls ignored
    step(0, 1, 0, 0, 0);
    ball(0); ball(0);
    chk("tp2_reason", fail_reason, 1);
    chk("tp2_idx", mismatch_idx, 1);
    ball(1);
    chk("tp2_count", ball_count, 2);
    $display("colour error: reason=%0d idx=%0d count=%0d", fail_reason, mismatch_idx, ball_count);

    // Board runs dry after two balls
    step(0, 1, 0, 0, 0);
    ball(0); ball(1);
    step(0, 0, 0, 0, 1);
    chk("tp3_reason", fail_reason, 2);
    chk("tp3_idx", mismatch_idx, 2);
    $display("short run: reason=%0d idx=%0d", fail_reason, mismatch_idx);

    // no_balls already high at start: no SHORT
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("nb_high_busy", busy, 1);

    // start and ball in the same cycle; then rst mid-run
    step(0, 1, 1, 1, 0);
    chk("start_ball_count", ball_count, 0);
    chk("start_ball_busy", busy, 1);
    ball(0); ball(1);
    step(1, 0, 0, 0, 0);
    chk("midrst_count", ball_count, 0);
    chk("midrst_busy", busy, 0);
    $display("mid-run reset: busy=%0d count=%0d", busy, ball_count);

    // Third ball mismatches: history shows accepted colours
    step(0, 1, 0, 0, 0);
    ball(0); ball(1); ball(1);
    chk("tp6_reason", fail_reason, 1);
    chk("tp6_idx", mismatch_idx, 2);
`ifdef TRAY_CHECKER_HISTORY_EN
    chk("tp6_history", history, 16'b110);
`endif

    // Ball coinciding with no_balls rising edge, both outcomes
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    ball(0);
    step(0, 0, 1, 1, 1);
    chk("coinc_short_idx", mismatch_idx, 2);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    ball(0); ball(1); ball(0);
    step(0, 0, 1, 1, 1);
    chk("coinc_pass", pass, 1);
    $display("coincident edge: pass=%0d", pass);

    // Randomised run against the model
    last_v = 0; nb = 0;
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 149) == 0);
      s = ($urandom_range(0, 24) == 0);
      v = !last_v && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) != 0 && m_balls.size() < 16) c = tgt_v[m_balls.size()];
      else c = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) nb = ~nb;
      step(r, s, v, c, nb);
      last_v = v;
    end
    $display("random: %0d cycles done", 1500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tray_checker.md
Name: tray_checker

Overview:
- Downstream consumer of the board's output-tray stream: watches each ball colour the board lands in the tray and compares it against a puzzle target pattern.
- Reports pass/fail and, on failure, the reason and the index of the first offending ball.
- Sits between the board and the puzzle-status/UI logic.
- Converts the board's event-style outputs into a clocked, synchronous verdict.

Parameters:
- MAX_BALLS, 16: capacity of the target pattern and of all counters.
- TARGET_LEN, 8: number of balls in the target pattern; legal range 1..MAX_BALLS.
- TARGET, 16'h00AA: target colours; bit i is the colour of tray slot i (0 = BLUE, 1 = RED). Bits at index TARGET_LEN and above are ignored.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; arms the checker for a new run
- ball_valid  in  1  one-cycle pulse; a ball has landed in the tray
- ball_color  in  1  colour of that ball (0 = BLUE, 1 = RED); valid only with ball_valid
- no_balls  in  1  level from the board; high once the board has run dry
- busy  out  1  high while in RUN
- done  out  1  high in PASS or FAIL
- pass  out  1  high in PASS only
- fail_reason  out  2  NONE / MISMATCH / SHORT / EXTRA
- mismatch_idx  out  $clog2(MAX_BALLS)  tray index of the first offending ball
- ball_count  out  $clog2(MAX_BALLS)+1  balls accepted this run

Behaviour:
- Reset (rst high at a clk edge):
  - state = IDLE
  - busy, done, pass = 0; fail_reason = NONE; mismatch_idx = 0; ball_count = 0
  - the internal no_balls history register is cleared to 0
  - rst overrides every other input, including in mid-run.
- State machine: IDLE, RUN, PASS, FAIL.
  - Outputs are registered: a verdict becomes visible on the cycle after the deciding input.
- start in any state:
  - next state is RUN; ball_count, mismatch_idx and fail_reason are cleared.
  - If start and ball_valid arrive in the same cycle, start wins and the ball is dropped.
- IDLE: ball_valid and no_balls are ignored.
- RUN, on ball_valid, with idx = ball_count:
  - ball_color != TARGET[idx] -> FAIL, fail_reason = MISMATCH, mismatch_idx = idx.
  - Otherwise, if idx == TARGET_LEN-1 -> PASS.
  - ball_count increments whenever ball_valid is sampled in RUN, including on the failing ball.
- RUN, on a no_balls rising edge (previous sample 0, current 1) with no ball_valid in the same cycle:
  - FAIL, fail_reason = SHORT, mismatch_idx = ball_count (the first missing slot).
- RUN, when ball_valid and a no_balls rising edge coincide:
  - the ball is evaluated first.
  - If that ball completes a PASS, the result is PASS; otherwise the ball's own verdict or the SHORT rule applies to the updated count.
- PASS, on ball_valid:
  - FAIL, fail_reason = EXTRA, mismatch_idx = TARGET_LEN; ball_count increments.
- FAIL is sticky until start or rst; further balls are ignored and ball_count is frozen.
- no_balls high already at start: no edge occurs, so SHORT is not raised. The run ends only by ball events or a later low-to-high transition.
- ball_count saturates at MAX_BALLS and never wraps.
- Input assumptions: all inputs are synchronous to clk. ball_valid is never high on two consecutive cycles.

Optional Feature:
- Macro: TRAY_CHECKER_HISTORY_EN.
- Defined:
  - adds output history [MAX_BALLS-1:0]; bit i = colour of accepted ball i.
  - history is cleared on rst and on start, and written on every ball accepted in RUN (including the failing one).
  - bits at index ball_count and above read 0.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package turingtumble_pkg:
  - colour constants BLUE = 0, RED = 1
  - checker state enum (IDLE, RUN, PASS, FAIL)
  - fail_reason codes: NONE = 0, MISMATCH = 1, SHORT = 2, EXTRA = 3
- Sub-module tt_rise_detect: registered one-cycle rising-edge pulse generator, synchronous reset. It is used for no_balls and is reusable for other board level signals.

Test Plan:
- TARGET_LEN = 4, TARGET = 4'b1010: start, then balls 0, 1, 0, 1 -> pass = 1 the cycle after the 4th ball, ball_count = 4, fail_reason = NONE.
- Same target, balls 0, 0 -> FAIL after the 2nd ball, fail_reason = MISMATCH, mismatch_idx = 1, ball_count = 2; a later ball leaves ball_count = 2.
- Same target, balls 0, 1, then no_balls rises -> FAIL, fail_reason = SHORT, mismatch_idx = 2.
- Reach PASS, then one more ball -> FAIL, fail_reason = EXTRA, mismatch_idx = 4, ball_count = 5.
- start and ball_valid in the same cycle -> ball_count = 0, state RUN. rst asserted mid-run after 2 balls -> all outputs at reset values on the next cycle.
- With TRAY_CHECKER_HISTORY_EN defined, balls 0, 1, 1 (3rd mismatches) -> history = 16'b110, fail_reason = MISMATCH, mismatch_idx = 2.
